// File: rtl/dr_load_controller.sv
// Sequences byte reads from memory into a 32-bit data register.
// Byte loads are sign- or zero-extended; word loads run as four byte writes in big- or little-endian order.
module dr_load_controller #(
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] addr,
   input  logic [1:0]        mode,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ready,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              dr_E,
   output logic [1:0]        dr_FunSel,
   output logic [7:0]        dr_In,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

   state_t            state_r, state_s;
   logic [1:0]        mode_r, mode_s;
   logic [1:0]        count_r, count_s;
   logic [1:0]        last_s;
   logic [TMR_W-1:0]  timer_r, timer_s;
   logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
   logic [1:0]        dr_funsel_r, dr_funsel_s;
   logic [7:0]        dr_in_r, dr_in_s;
   logic              mem_req_r, mem_req_s;
   logic              dr_e_r, dr_e_s;
   logic              busy_r, busy_s;
   logic              done_r, done_s;
   logic              error_r, error_s;

   // Next-state logic; every output is computed from the next state and registered below.
   always_comb begin
      state_s     = state_r;
      mode_s      = mode_r;
      count_s     = count_r;
      timer_s     = timer_r;
      mem_addr_s  = mem_addr_r;
      dr_funsel_s = dr_funsel_r;
      dr_in_s     = dr_in_r;
      error_s     = error_r;
      last_s      = mode_r[1] ? 2'd3 : 2'd0;
      case (state_r)
         IDLE: begin
            if (start) begin
               mode_s     = mode;
               count_s    = 2'd0;
               timer_s    = '0;
               mem_addr_s = addr;
               error_s    = 1'b0;
               state_s    = REQ;
            end else begin
               state_s = IDLE;
            end
         end
         REQ: begin
            if (mem_ready) begin
               dr_in_s = mem_rdata;
               state_s = WRITE;
            end else if (timer_r == TMR_LAST) begin
               error_s = 1'b1;
               state_s = DONE;
            end else begin
               timer_s = timer_r + TMR_W'(1);
            end
         end
         WRITE: begin
            if (count_r != last_s) begin
               count_s    = count_r + 2'd1;
               mem_addr_s = mem_addr_r + ADDR_W'(1);
               timer_s    = '0;
               state_s    = REQ;
            end else begin
               state_s = DONE;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      // The function select only moves when a write is actually issued.
      if (state_s == WRITE) begin
         dr_funsel_s = mode_r;
      end else begin
         dr_funsel_s = dr_funsel_s;
      end
      mem_req_s = (state_s == REQ);
      dr_e_s    = (state_s == WRITE);
      busy_s    = (state_s != IDLE);
      done_s    = (state_s == DONE);
   end

   // State and output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= IDLE;
         mode_r      <= 2'd0;
         count_r     <= 2'd0;
         timer_r     <= '0;
         mem_addr_r  <= '0;
         dr_funsel_r <= 2'd0;
         dr_in_r     <= 8'd0;
         mem_req_r   <= 1'b0;
         dr_e_r      <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         error_r     <= 1'b0;
      end else begin
         state_r     <= state_s;
         mode_r      <= mode_s;
         count_r     <= count_s;
         timer_r     <= timer_s;
         mem_addr_r  <= mem_addr_s;
         dr_funsel_r <= dr_funsel_s;
         dr_in_r     <= dr_in_s;
         mem_req_r   <= mem_req_s;
         dr_e_r      <= dr_e_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
         error_r     <= error_s;
      end
   end

   assign mem_req   = mem_req_r;
   assign mem_addr  = mem_addr_r;
   assign dr_E      = dr_e_r;
   assign dr_FunSel = dr_funsel_r;
   assign dr_In     = dr_in_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign error     = error_r;

endmodule

// File: tb/tb_dr_load_controller.sv
// Randomized self-checking bench: a behavioural memory, a 32-bit data register model and
// a per-transfer expectation computed from the load rules (byte count, endianness, latency).
module tb_dr_load_controller;

   localparam int AW = 16;
   localparam int TO = 15;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [1:0]    mode = 2'd0;
   logic [7:0]    mem_rdata = 8'd0;
   logic          mem_ready = 1'b0;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          dr_E;
   logic [1:0]    dr_FunSel;
   logic [7:0]    dr_In;
   logic          busy;
   logic          done;
   logic          error;

   int tests_run = 0;
   int tests_failed = 0;

   dr_load_controller #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .addr(addr), .mode(mode),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_req(mem_req), .mem_addr(mem_addr),
      .dr_E(dr_E), .dr_FunSel(dr_FunSel), .dr_In(dr_In), .busy(busy), .done(done), .error(error)
   );

   always #5 clock = ~clock;

   // Memory: answers a request after ready_delay idle cycles; random noise on ready when not requested.
   logic [7:0] mem [0:65535];
   int  ready_delay = 0;
   bit  never_ready = 1'b0;
   int  wait_cnt = 0;
   always @(negedge clock) begin
      if (mem_req) begin
         if (!never_ready && wait_cnt >= ready_delay) begin
            mem_ready = 1'b1;
            mem_rdata = mem[mem_addr];
            wait_cnt  = 0;
         end else begin
            mem_ready = 1'b0;
            mem_rdata = 8'($urandom);
            wait_cnt  = wait_cnt + 1;
         end
      end else begin
         mem_ready = 1'($urandom);
         mem_rdata = 8'($urandom);
         wait_cnt  = 0;
      end
   end

   // Data register model plus a log of every write strobe and done pulse.
   logic [31:0]   dr_model = 32'd0;
   logic [1:0]    q_fun[$];
   logic [7:0]    q_in[$];
   logic [AW-1:0] q_addr[$];
   int            q_req_bad = 0;
   int            done_cnt = 0;
   always @(negedge clock) begin
      if (dr_E) begin
         q_fun.push_back(dr_FunSel);
         q_in.push_back(dr_In);
         q_addr.push_back(mem_addr);
         if (mem_req) q_req_bad = q_req_bad + 1;
         case (dr_FunSel)
            2'd0:    dr_model = {{24{dr_In[7]}}, dr_In};
            2'd1:    dr_model = {24'd0, dr_In};
            2'd2:    dr_model = {dr_model[23:0], dr_In};
            default: dr_model = {dr_In, dr_model[31:8]};
         endcase
      end
      if (done) done_cnt = done_cnt + 1;
   end

   task automatic clear_log();
      q_fun.delete(); q_in.delete(); q_addr.delete();
      q_req_bad = 0; done_cnt = 0; dr_model = 32'd0;
   endtask

   task automatic do_xfer(input logic [1:0] m, input logic [AW-1:0] a, input int dly,
                          input bit noready, input bit spam, input string tag);
      logic [7:0]  b [4];
      logic [31:0] exp_reg;
      int nbytes, exp_lat, cyc;
      bit seen;
      for (int i = 0; i < 4; i++) begin
         b[i] = 8'($urandom);
         mem[16'(a + AW'(i))] = b[i];
      end
      nbytes  = noready ? 0 : (m[1] ? 4 : 1);
      exp_lat = noready ? TO + 1 : nbytes * (2 + dly) + 1;
      case (m)
         2'd0:    exp_reg = {{24{b[0][7]}}, b[0]};
         2'd1:    exp_reg = {24'd0, b[0]};
         2'd2:    exp_reg = {b[0], b[1], b[2], b[3]};
         default: exp_reg = {b[3], b[2], b[1], b[0]};
      endcase
      ready_delay = dly;
      never_ready = noready;
      @(negedge clock);
      clear_log();
      start = 1'b1; addr = a; mode = m;
      cyc = 0; seen = 1'b0;
      while (!seen && cyc < 200) begin
         @(negedge clock);
         cyc++;
         if (spam) begin
            addr = AW'($urandom); mode = 2'($urandom);
         end else begin
            start = 1'b0;
         end
         if (cyc == 1) begin
            tests_run++;
            if ({busy, error} !== 2'b10) begin
               tests_failed++;
               $display("FAIL %s accept: busy,error=%b want 10", tag, {busy, error});
            end
         end
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      tests_run++;
      if (!seen) begin
         tests_failed++;
         $display("FAIL %s done_timeout: no done within %0d cycles", tag, cyc);
      end
      tests_run++;
      if (cyc != exp_lat) begin
         tests_failed++;
         $display("FAIL %s latency: got %0d want %0d", tag, cyc, exp_lat);
      end
      tests_run++;
      if (error !== noready) begin
         tests_failed++;
         $display("FAIL %s error: got %b want %b", tag, error, noready);
      end
      @(negedge clock);
      @(negedge clock);
      tests_run++;
      if ({busy, done, done_cnt} !== {1'b0, 1'b0, 32'd1}) begin
         tests_failed++;
         $display("FAIL %s after_done: busy=%b done=%b pulses=%0d want 0,0,1", tag, busy, done, done_cnt);
      end
      tests_run++;
      if (q_fun.size() != nbytes || q_req_bad != 0) begin
         tests_failed++;
         $display("FAIL %s dr_E_count: got %0d (req overlap %0d) want %0d", tag, q_fun.size(), q_req_bad, nbytes);
      end
      for (int i = 0; i < nbytes && i < q_fun.size(); i++) begin
         tests_run++;
         if ({q_fun[i], q_in[i], q_addr[i]} !== {m, b[i], AW'(a + AW'(i))}) begin
            tests_failed++;
            $display("FAIL %s write%0d: fun=%0d in=%h addr=%h want fun=%0d in=%h addr=%h",
                     tag, i, q_fun[i], q_in[i], q_addr[i], m, b[i], AW'(a + AW'(i)));
         end
      end
      if (!noready) begin
         tests_run++;
         if (dr_model !== exp_reg) begin
            tests_failed++;
            $display("FAIL %s register: got %h want %h", tag, dr_model, exp_reg);
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #1;
      tests_run++;
      if ({mem_req, mem_addr, dr_E, dr_FunSel, dr_In, busy, done, error} !== '0) begin
         tests_failed++;
         $display("FAIL reset_state: got %h want 0",
                  {mem_req, mem_addr, dr_E, dr_FunSel, dr_In, busy, done, error});
      end
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_directed();
      do_xfer(2'd0, 16'h0010, 0, 1'b0, 1'b0, "byte_sext");
      do_xfer(2'd2, 16'h0100, 0, 1'b0, 1'b0, "word_be");
      do_xfer(2'd3, 16'hFFFE, 2, 1'b0, 1'b0, "word_le_wrap");
   endtask

   task automatic test_timeout();
      do_xfer(2'd1, 16'h1234, 0, 1'b1, 1'b0, "timeout");
      tests_run++;
      if (error !== 1'b1) begin
         tests_failed++;
         $display("FAIL timeout_error_hold: got %b want 1", error);
      end
      do_xfer(2'd1, 16'h1234, 1, 1'b0, 1'b0, "after_timeout");
   endtask

   task automatic test_reset_mid();
      int guard;
      logic [AW-1:0] a;
      a = AW'($urandom);
      for (int i = 0; i < 4; i++) mem[16'(a + AW'(i))] = 8'($urandom);
      ready_delay = 1; never_ready = 1'b0;
      @(negedge clock);
      clear_log();
      start = 1'b1; addr = a; mode = 2'd2;
      @(negedge clock);
      start = 1'b0;
      guard = 0;
      while (q_fun.size() < 2 && guard < 100) begin
         @(negedge clock);
         guard++;
      end
      reset_n = 1'b0;
      #1;
      tests_run++;
      if ({mem_req, mem_addr, dr_E, dr_FunSel, dr_In, busy, done, error} !== '0 || guard >= 100) begin
         tests_failed++;
         $display("FAIL reset_mid_state: got %h want 0 (guard %0d)",
                  {mem_req, mem_addr, dr_E, dr_FunSel, dr_In, busy, done, error}, guard);
      end
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
      tests_run++;
      if (q_fun.size() != 2 || done_cnt != 0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid_abort: writes=%0d done=%0d busy=%b want 2,0,0", q_fun.size(), done_cnt, busy);
      end
      do_xfer(2'd2, AW'($urandom), 0, 1'b0, 1'b0, "after_reset");
   endtask

   task automatic test_back_to_back();
      do_xfer(2'd2, 16'h4000, 0, 1'b0, 1'b1, "start_spam_word");
      do_xfer(2'd0, 16'h00FF, 1, 1'b0, 1'b1, "start_spam_byte");
   endtask

   task automatic test_random();
      for (int n = 0; n < 10; n++) begin
         do_xfer(2'($urandom), AW'($urandom), int'($urandom_range(0, 3)), 1'b0, 1'($urandom), "random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
